// File: rtl/nios2_debug_slave_cmdq.sv
// Debug-slave command queue: captures update-DR / update-IR strobes from the
// JTAG (tck) domain, turns each rising strobe into a queued command, and
// presents the queue head to a valid/ready consumer in the clk domain.
module nios2_debug_slave_cmdq #(
  parameter int SR_WIDTH    = 38,
  parameter int IR_WIDTH    = 2,
  parameter int DEPTH       = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [SR_WIDTH-1:0]        sr,
  input  logic [IR_WIDTH-1:0]        ir_in,
  input  logic                       vs_udr,
  input  logic                       vs_uir,
  output logic                       cmd_valid,
  input  logic                       cmd_ready,
  output logic [SR_WIDTH-1:0]        cmd_data,
  output logic [IR_WIDTH-1:0]        cmd_ir,
  output logic                       cmd_kind,
  output logic [(2**IR_WIDTH)-1:0]   take_action,
  output logic                       overflow,
  input  logic                       clear_overflow,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  // Entry layout: {kind, ir, data}
  localparam int EW = 1 + IR_WIDTH + SR_WIDTH;
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);
  localparam int NA = 2**IR_WIDTH;
  localparam int AW = $clog2(SYNC_STAGES+2);

  localparam logic [PW-1:0] PTR_ONE  = PW'(1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);
  localparam logic [AW-1:0] ARM_ONE  = AW'(1);
  localparam logic [AW-1:0] ARM_DONE = AW'(SYNC_STAGES+1);

  logic [SYNC_STAGES-1:0] udrSync_q, uirSync_q;
  logic                   udrPrev_q, uirPrev_q;
  logic [AW-1:0]          armCnt_q;
  logic                   armed;
  logic                   udrEvt, uirEvt;
  logic [EW-1:0]          udrEntry, uirEntry;

  logic                   stgValid_q, stgValid_d;
  logic [EW-1:0]          stgEntry_q, stgEntry_d;
  logic                   pendValid_q, pendValid_d;
  logic [EW-1:0]          pendEntry_q, pendEntry_d;

  logic [EW-1:0]          mem_q [DEPTH];
  logic [PW-1:0]          wrPtr_q, rdPtr_q;
  logic [CW-1:0]          count_q, count_d;
  logic [NA-1:0]          takeAction_q, takeAction_d;
  logic [NA-1:0]          actOneHot;
  logic                   overflow_q, overflow_d;
  logic                   full, popFire, pushAccept, pushDrop;
  logic [EW-1:0]          headEntry;

  assign armed    = (armCnt_q == ARM_DONE);
  assign udrEvt   = armed & udrSync_q[SYNC_STAGES-1] & ~udrPrev_q;
  assign uirEvt   = armed & uirSync_q[SYNC_STAGES-1] & ~uirPrev_q;
  assign udrEntry = {1'b0, ir_in, sr};
  assign uirEntry = {1'b1, ir_in, {SR_WIDTH{1'b0}}};

  // Strobe synchronizers, edge-detect history and the post-reset arming delay
  always_ff @(posedge clk) begin
    if (reset) begin
      udrSync_q <= '0;
      uirSync_q <= '0;
      udrPrev_q <= 1'b0;
      uirPrev_q <= 1'b0;
      armCnt_q  <= '0;
    end else begin
      udrSync_q <= {udrSync_q[SYNC_STAGES-2:0], vs_udr};
      uirSync_q <= {uirSync_q[SYNC_STAGES-2:0], vs_uir};
      udrPrev_q <= udrSync_q[SYNC_STAGES-1];
      uirPrev_q <= uirSync_q[SYNC_STAGES-1];
      if (!armed) armCnt_q <= armCnt_q + ARM_ONE;
    end
  end

  // Pick the single entry to push next cycle; an older pending entry goes
  // first and whatever is left over waits in the one-entry pending slot
  always_comb begin
    stgValid_d  = 1'b0;
    stgEntry_d  = '0;
    pendValid_d = 1'b0;
    pendEntry_d = '0;
    if (pendValid_q) begin
      stgValid_d = 1'b1;
      stgEntry_d = pendEntry_q;
      if (udrEvt) begin
        pendValid_d = 1'b1;
        pendEntry_d = udrEntry;
      end else if (uirEvt) begin
        pendValid_d = 1'b1;
        pendEntry_d = uirEntry;
      end
    end else if (udrEvt) begin
      stgValid_d = 1'b1;
      stgEntry_d = udrEntry;
      if (uirEvt) begin
        pendValid_d = 1'b1;
        pendEntry_d = uirEntry;
      end
    end else if (uirEvt) begin
      stgValid_d = 1'b1;
      stgEntry_d = uirEntry;
    end
  end

  assign full       = (count_q == CNT_FULL);
  assign popFire    = cmd_valid & cmd_ready;
  assign pushAccept = stgValid_q & (~full | popFire);
  assign pushDrop   = stgValid_q & full & ~popFire;

  // Decode the staged instruction into the one-hot action pattern
  always_comb begin
    actOneHot = '0;
    actOneHot[stgEntry_q[SR_WIDTH +: IR_WIDTH]] = 1'b1;
  end

  // Next occupancy, action pulse and sticky overflow flag
  always_comb begin
    count_d = count_q;
    if (pushAccept && !popFire) count_d = count_q + CNT_ONE;
    else if (!pushAccept && popFire) count_d = count_q - CNT_ONE;
    takeAction_d = (pushAccept && !stgEntry_q[EW-1]) ? actOneHot : '0;
    overflow_d = overflow_q;
    if (pushDrop) overflow_d = 1'b1;
    else if (clear_overflow) overflow_d = 1'b0;
  end

  // Control state: staging/pending slots, pointers, count and flags
  always_ff @(posedge clk) begin
    if (reset) begin
      stgValid_q   <= 1'b0;
      stgEntry_q   <= '0;
      pendValid_q  <= 1'b0;
      pendEntry_q  <= '0;
      wrPtr_q      <= '0;
      rdPtr_q      <= '0;
      count_q      <= '0;
      takeAction_q <= '0;
      overflow_q   <= 1'b0;
    end else begin
      stgValid_q   <= stgValid_d;
      stgEntry_q   <= stgEntry_d;
      pendValid_q  <= pendValid_d;
      pendEntry_q  <= pendEntry_d;
      if (pushAccept) wrPtr_q <= wrPtr_q + PTR_ONE;
      if (popFire) rdPtr_q <= rdPtr_q + PTR_ONE;
      count_q      <= count_d;
      takeAction_q <= takeAction_d;
      overflow_q   <= overflow_d;
    end
  end

  // Queue storage is left uncleared; the head is masked while the queue is empty
  always_ff @(posedge clk) begin
    if (pushAccept && !reset) mem_q[wrPtr_q] <= stgEntry_q;
  end

  assign headEntry   = mem_q[rdPtr_q];
  assign cmd_valid   = (count_q != '0);
  assign cmd_data    = cmd_valid ? headEntry[SR_WIDTH-1:0] : '0;
  assign cmd_ir      = cmd_valid ? headEntry[SR_WIDTH +: IR_WIDTH] : '0;
  assign cmd_kind    = cmd_valid & headEntry[EW-1];
  assign take_action = takeAction_q;
  assign overflow    = overflow_q;
  assign count       = count_q;

endmodule

// File: doc/nios2_debug_slave_cmdq.md
NIOS2_DEBUG_SLAVE_CMDQ -- requirements
Module: nios2_debug_slave_cmdq

Interface
REQ-001 The block SHALL have the following parameters (name, default, meaning):
- SR_WIDTH, 38: debug shift-register width.
- IR_WIDTH, 2: virtual-JTAG instruction width.
- DEPTH, 4: command queue entries; power of two, at least 2.
- SYNC_STAGES, 2: synchronizer flops per strobe; at least 2.

REQ-002 The block SHALL have the following ports (name, direction, width, meaning):
- clk, in, 1: single system clock.
- reset, in, 1: synchronous, active-high reset.
- sr, in, SR_WIDTH: shift-register contents; quasi-static while vs_udr or vs_uir is high.
- ir_in, in, IR_WIDTH: current virtual-JTAG instruction; quasi-static.
- vs_udr, in, 1: update-DR level from the tck domain.
- vs_uir, in, 1: update-IR level from the tck domain.
- cmd_valid, out, 1: the queue head is valid.
- cmd_ready, in, 1: the consumer accepts the head.
- cmd_data, out, SR_WIDTH: head data.
- cmd_ir, out, IR_WIDTH: head instruction.
- cmd_kind, out, 1: 0 = update-DR entry, 1 = update-IR entry.
- take_action, out, 2**IR_WIDTH: one-hot pulse decoded from the accepted update-DR instruction.
- overflow, out, 1: sticky lost-command flag.
- clear_overflow, in, 1: clears overflow.
- count, out, clog2(DEPTH+1): current queue occupancy.

REQ-003 The block SHALL run entirely on clk, and reset SHALL be synchronous and active-high.

Function
REQ-004 vs_udr and vs_uir SHALL each pass through a SYNC_STAGES-flop synchronizer followed by a previous-value flop; an event SHALL be a 0->1 transition at the synchronizer output.

REQ-005 An arming counter SHALL suppress event detection for SYNC_STAGES+1 cycles after reset deasserts, so a level already high at reset release produces no event.

REQ-006 On a udr event, the block SHALL form entry {kind=0, ir=ir_in, data=sr}, sampled in the event cycle.

REQ-007 On a uir event, the block SHALL form entry {kind=1, ir=ir_in, data=0}.

REQ-008 At most one push SHALL occur per cycle. When udr and uir events coincide, the udr entry SHALL be pushed and the uir entry held in a one-entry pending register, then pushed the next cycle.

REQ-009 A pending uir entry SHALL take priority over a new udr event in the following cycle; that udr event SHALL in turn be held pending. Two pending slots SHALL never be needed, because synchronized strobes are at least 2 cycles apart.

REQ-010 Queue: circular buffer of DEPTH entries.
- Write and read pointers are log2(DEPTH) bits wide and wrap modulo DEPTH.
- count ranges 0..DEPTH.

REQ-011 cmd_valid SHALL equal (count != 0).
- cmd_data, cmd_ir and cmd_kind SHALL show the head entry and hold stable while cmd_valid=1 and cmd_ready=0.

REQ-012 A pop SHALL occur when cmd_valid and cmd_ready are both 1 in a cycle.

REQ-013 Push into an empty queue: cmd_valid SHALL rise the cycle after the push. Total latency from a vs_udr rise to cmd_valid is SYNC_STAGES+2 clk cycles.

REQ-014 Push and pop in the same cycle SHALL leave count unchanged. This SHALL also hold when count==DEPTH; the push is accepted.

REQ-015 A push with count==DEPTH and no pop SHALL be dropped. In that case:
- overflow SHALL set in the next cycle;
- queue contents and count SHALL be unchanged;
- take_action SHALL NOT pulse.

REQ-016 clear_overflow=1 SHALL clear overflow the next cycle. If a drop occurs in the same cycle, set SHALL win.

REQ-017 For each accepted kind=0 push with ir=k, take_action[k] SHALL be 1 for exactly the cycle after the push, and all other bits 0. kind=1 pushes SHALL NOT assert take_action.

Reset
REQ-018 While reset=1, the following SHALL be cleared at the next clk edge:
- synchronizer, previous-value and arming flops;
- pending register and both pointers;
- count, cmd_valid, take_action and overflow.

REQ-019 cmd_data, cmd_ir and cmd_kind SHALL read 0 after reset. Queue storage need not be cleared.

REQ-020 Reset asserted mid-operation SHALL discard all queued and pending entries within one cycle, with no take_action pulse.

Verification
REQ-021 Single udr: sr=38'h2A_5A5A_5A5A, ir_in=2'b10, vs_udr held high 10 cycles.
- -> cmd_valid=1 exactly 4 cycles after the rise, with cmd_data=38'h2A_5A5A_5A5A, cmd_ir=2, cmd_kind=0.
- -> take_action=4'b0100 for 1 cycle.
- -> count=1.

REQ-022 Overflow: 5 udr events with cmd_ready=0 and DEPTH=4.
- -> count=4 and overflow=1.
- -> the first 4 entries pop in order.
- -> clear_overflow then returns overflow to 0.

REQ-023 Coincident strobes: vs_udr and vs_uir rise together.
- -> two entries: kind=0 first, then kind=1.
- -> count=2 with cmd_ready=0.

REQ-024 Full queue with cmd_ready=1 and a push in the same cycle.
- -> count stays 4, overflow stays 0, and FIFO order is preserved across pointer wrap.

REQ-025 vs_udr already high when reset deasserts.
- -> no entry and no take_action.
- A later low->high transition produces exactly one entry.

REQ-026 Reset pulsed with count=3 and a pending uir entry.
- -> count=0 and cmd_valid=0 the next cycle, and take_action stays 0.
